ram_chip_param: RTL and testbench

Parametrised dual-port RAM for the SoC memory subsystem. One synchronous write port and one synchronous read port share a single clock. Adds these capabilities:

- configurable width, depth and read latency;
- per-byte write enables;
- deterministic read-during-write behaviour;
- a hardware zero-initialisation sequencer after reset;
- optional per-byte parity checking.

It is the drop-in successor for fixed 64-bit/4K-word RAM instances behind bus slaves and DMA buffers.

---
 rtl/ram_chip_param.sv | 129 ++++++++++++
 tb/tb_ram_chip_param.sv | 118 +++++++++++
 2 files changed

// File: rtl/ram_chip_param.sv
// ram_chip_param: dual-port RAM with byte enables, write-first collisions and zero-init sequencer.
// Optional per-byte even parity storage and checking is enabled by defining RAM_PARITY_EN.
module ram_chip_param #(
   parameter int RAM_WIDTH = 64,
   parameter int ADDR_SIZE = 12,
   parameter int OUT_REG   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   chip_en,
   input  logic                   write,
   input  logic [ADDR_SIZE-1:0]   wr_address,
   input  logic [RAM_WIDTH-1:0]   data_in,
   input  logic [RAM_WIDTH/8-1:0] byte_en,
   input  logic                   err_inj,
   input  logic                   read,
   input  logic [ADDR_SIZE-1:0]   rd_address,
   output logic [RAM_WIDTH-1:0]   data_out,
   output logic                   data_valid,
   output logic                   ready,
   output logic                   parity_err
);
   localparam int NB    = RAM_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_SIZE;
   typedef enum logic {INIT, RUN} state_t;
   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
   logic [RAM_WIDTH-1:0]   mem [DEPTH];
   logic                   run, we, re, coll;
   logic [ADDR_SIZE-1:0]   wa;
   logic [RAM_WIDTH-1:0]   wd, rd_word, d1_q;
   logic [NB-1:0]          wbe;
   logic                   rd_perr, v1_q, p1_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = (cnt_q == ADDR_SIZE'(DEPTH - 1)) ? RUN : INIT;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // The init sweep borrows the write port, so one write path serves both modes
   assign run   = (state_q == RUN);
   assign ready = run;
   assign we    = run ? (chip_en & write) : 1'b1;
   assign wa    = run ? wr_address : cnt_q;
   assign wd    = run ? data_in : '0;
   assign wbe   = run ? byte_en : '1;
   assign re    = run & chip_en & read;
   assign coll  = we & (wa == rd_address);
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++)
         if (we && wbe[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
   end
   always_comb begin
      rd_word = mem[rd_address];
      for (int i = 0; i < NB; i++)
         if (coll && wbe[i]) rd_word[8*i +: 8] = wd[8*i +: 8];
   end
`ifdef RAM_PARITY_EN
   logic [NB-1:0] par [DEPTH];
   logic [NB-1:0] wp, rp;
   always_comb begin
      wp = '0;
      for (int i = 0; i < NB; i++) wp[i] = ^wd[8*i +: 8];
      wp[0] = wp[0] ^ (run & err_inj);
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++)
         if (we && wbe[i]) par[wa][i] <= wp[i];
   end
   always_comb begin
      rp      = par[rd_address];
      rd_perr = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (coll && wbe[i]) rp[i] = wp[i];
         rd_perr = rd_perr | (rp[i] ^ (^rd_word[8*i +: 8]));
      end
   end
`else
   logic unused_err_inj;
   assign unused_err_inj = err_inj;
   assign rd_perr        = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         p1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= re;
         p1_q <= re & rd_perr;
         if (re) d1_q <= rd_word;
      end
   end
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                 v2_q, p2_q;
         logic [RAM_WIDTH-1:0] d2_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v2_q <= 1'b0;
               p2_q <= 1'b0;
               d2_q <= '0;
            end else begin
               v2_q <= v1_q;
               p2_q <= p1_q;
               if (v1_q) d2_q <= d1_q;
            end
         end
         assign data_out   = d2_q;
         assign data_valid = v2_q;
         assign parity_err = p2_q;
      end else begin : g_noreg
         assign data_out   = d1_q;
         assign data_valid = v1_q;
         assign parity_err = p1_q;
      end
   endgenerate
endmodule

// File: tb/tb_ram_chip_param.sv
// tb_ram_chip_param: directed checks of init, byte enables, collisions, streaming and parity.
module tb_ram_chip_param;
   localparam int OUT_REG = 0;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        chip_en = 1'b0, write = 1'b0, read = 1'b0, err_inj = 1'b0;
   logic [11:0] wr_address = '0, rd_address = '0;
   logic [63:0] data_in = '0, data_out;
   logic [7:0]  byte_en = '0;
   logic        data_valid, ready, parity_err;
   int          n_run = 0, n_fail = 0;
   ram_chip_param #(.RAM_WIDTH(64), .ADDR_SIZE(12), .OUT_REG(OUT_REG)) dut (
      .clk(clk), .rst(rst), .chip_en(chip_en), .write(write), .wr_address(wr_address),
      .data_in(data_in), .byte_en(byte_en), .err_inj(err_inj), .read(read),
      .rd_address(rd_address), .data_out(data_out), .data_valid(data_valid),
      .ready(ready), .parity_err(parity_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be, input logic inj);
      chip_en = 1'b1; write = 1'b1; wr_address = a; data_in = d; byte_en = be; err_inj = inj;
      cyc();
      write = 1'b0; err_inj = 1'b0;
   endtask
   task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp, input logic pexp);
      chip_en = 1'b1; read = 1'b1; rd_address = a;
      cyc();
      read = 1'b0;
      repeat (OUT_REG) cyc();
      chk({tag, "_valid"}, data_valid, 1'b1);
      chk({tag, "_data"}, data_out, exp);
      chk({tag, "_perr"}, parity_err, pexp);
   endtask
   task automatic do_init(input string tag);
      int n = 0;
      logic saw_v = 1'b0;
      rst = 1'b0; chip_en = 1'b1; read = 1'b1; rd_address = 12'd7;
      while (!ready && n < 5000) begin
         cyc();
         n++;
         saw_v = saw_v | data_valid;
      end
      read = 1'b0;
      chk({tag, "_len"}, n, 4096);
      chk({tag, "_novalid"}, saw_v, 1'b0);
      cyc();
      chk({tag, "_idle"}, data_valid, 1'b0);
   endtask
   initial begin
      int pulses;
      repeat (2) cyc();
      chk("rst_data", data_out, 64'h0);
      chk("rst_valid", data_valid, 1'b0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_perr", parity_err, 1'b0);
      do_init("init");
      rd("zero7", 12'd7, 64'h0, 1'b0);
      rd("zero_top", 12'd4095, 64'h0, 1'b0);
      rd("zero0", 12'd0, 64'h0, 1'b0);
      wr(12'd5, 64'hA1B2_C3D4_E5F6_7890, 8'hFF, 1'b0);
      rd("basic", 12'd5, 64'hA1B2_C3D4_E5F6_7890, 1'b0);
      wr(12'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
      rd("byte_en", 12'd5, 64'hA1B2_C3D4_FFFF_FFFF, 1'b0);
      wr(12'd5, 64'h0, 8'h00, 1'b0);
      rd("be_zero", 12'd5, 64'hA1B2_C3D4_FFFF_FFFF, 1'b0);
      write = 1'b1; wr_address = 12'd9; data_in = 64'h1122_3344_5566_7788; byte_en = 8'hF0;
      rd("collide", 12'd9, 64'h1122_3344_0000_0000, 1'b0);
      write = 1'b0;
      rd("collide_after", 12'd9, 64'h1122_3344_0000_0000, 1'b0);
      write = 1'b1; wr_address = 12'd10; data_in = 64'hDEAD_BEEF_0BAD_F00D; byte_en = 8'hFF;
      rd("indep", 12'd5, 64'hA1B2_C3D4_FFFF_FFFF, 1'b0);
      write = 1'b0;
      rd("indep_wr", 12'd10, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
      for (int i = 0; i < 4; i++) wr(12'(i), 64'h100 + 64'(i), 8'hFF, 1'b0);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         chip_en = (c != 4);
         read = (c <= 4);
         rd_address = 12'(c % 4);
         cyc();
         if (data_valid) begin
            chk("stream_data", data_out, 64'h100 + 64'(pulses));
            pulses++;
         end
      end
      chip_en = 1'b1; read = 1'b0;
      chk("stream_count", pulses, 4);
      chk("stream_hold", data_out, 64'h103);
`ifdef RAM_PARITY_EN
      wr(12'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
      rd("par_inj", 12'd3, 64'h0123_4567_89AB_CDEF, 1'b1);
      wr(12'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
      rd("par_clean", 12'd3, 64'h0123_4567_89AB_CDEF, 1'b0);
`endif
      read = 1'b1; rd_address = 12'd5;
      #2 rst = 1'b1;
      #1;
      chk("rerst_ready", ready, 1'b0);
      chk("rerst_valid", data_valid, 1'b0);
      chk("rerst_data", data_out, 64'h0);
      read = 1'b0;
      cyc();
      do_init("reinit");
      rd("rezero5", 12'd5, 64'h0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
